sbox_iter128: RTL and testbench

- Sequential, parametrised AES SubBytes / InvSubBytes engine for a 128-bit state.
- Runs LANES S-box lookups per cycle and finishes a block in 16/LANES cycles.
- Uses a valid/ready handshake on input and output.
- Sits between the round-key XOR and ShiftRows in the round datapath. Replaces the fully parallel combinational substitution when area matters.

---
 rtl/aes_pkg.sv | 50 +++++
 rtl/aes_sbox_lut.sv | 14 +
 rtl/sbox_iter128.sv | 125 ++++++++++++
 tb/tb_sbox_iter128.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES substitution tables, FSM encoding and block geometry.
package aes_pkg;

    localparam int unsigned BLOCK_BYTES = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/aes_sbox_lut.sv
// Single-byte forward/inverse AES S-box, pure combinational ROM lookup.
module aes_sbox_lut
    import aes_pkg::*;
(
    input  logic [7:0] value,
    input  logic       inv,
    output logic [7:0] result
);

    always_comb begin
        result = inv ? INV_SBOX[value] : SBOX[value];
    end

endmodule

// File: rtl/sbox_iter128.sv
// Iterative SubBytes/InvSubBytes over a 128-bit state, LANES bytes per cycle,
// with valid/ready handshakes on both sides and a synchronous abort.
module sbox_iter128
    import aes_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    input  logic         abort,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int unsigned NSTEP = BLOCK_BYTES / LANES;
    localparam int unsigned CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam int unsigned LW    = LANES * 8;

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("sbox_iter128: LANES must be 1, 2, 4, 8 or 16");
    end

    state_t                      state_q, state_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic                        mode_q, mode_d;
    logic [NSTEP-1:0][LW-1:0]    data_q, data_d;
    logic                        in_ready_d, out_valid_d, busy_d;
    logic [LW-1:0]               lane_in, lane_out;

    // Chunk cnt of the state feeds the lane array; results are written back in place.
    assign lane_in  = data_q[cnt_q];
    assign out_data = data_q;

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        aes_sbox_lut u_lut (
            .value  (lane_in[8*j +: 8]),
            .inv    (mode_q),
            .result (lane_out[8*j +: 8])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mode_q    <= 1'b0;
            data_q    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            data_q    <= data_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            busy      <= busy_d;
        end
    end

    // Abort overrides everything, including an acceptance in IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        data_d  = data_q;
        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_d  = in_data;
                        mode_d  = in_inv;
                        cnt_d   = '0;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    data_d[cnt_q] = lane_out;
                    if (cnt_q == CW'(NSTEP - 1)) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Handshake outputs are decoded from the next state so they register alongside it.
    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        case (state_d)
            IDLE:    in_ready_d  = 1'b1;
            BUSY:    busy_d      = 1'b1;
            DONE: begin
                out_valid_d = 1'b1;
                busy_d      = 1'b1;
            end
            default: in_ready_d  = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_sbox_iter128.sv
// Directed bench for sbox_iter128 at LANES = 1, 2, 4 and 16 driven in lockstep.
module tb_sbox_iter128;

    localparam int NDUT = 4;
    localparam int LANES_OF [NDUT] = '{1, 2, 4, 16};

    localparam logic [127:0] FWD_IN  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FWD_OUT = 128'h638293c31bfc33f5c4eeacea4bc12816;
    localparam logic [127:0] ALL63   = {16{8'h63}};

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [127:0] in_data;
    logic         in_inv;
    logic         abort;
    logic         out_ready;

    logic         ir [NDUT];
    logic         ov [NDUT];
    logic         bz [NDUT];
    logic [127:0] od [NDUT];

    int           checks = 0;
    int           errors = 0;
    int           lat [NDUT];
    logic [127:0] res [NDUT];

    always #5 clk = ~clk;

    sbox_iter128 #(.LANES(1)) u_l1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
        .in_inv(in_inv), .abort(abort), .out_valid(ov[0]), .out_ready(out_ready),
        .out_data(od[0]), .busy(bz[0])
    );
    sbox_iter128 #(.LANES(2)) u_l2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
        .in_inv(in_inv), .abort(abort), .out_valid(ov[1]), .out_ready(out_ready),
        .out_data(od[1]), .busy(bz[1])
    );
    sbox_iter128 #(.LANES(4)) u_l4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
        .in_inv(in_inv), .abort(abort), .out_valid(ov[2]), .out_ready(out_ready),
        .out_data(od[2]), .busy(bz[2])
    );
    sbox_iter128 #(.LANES(16)) u_l16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]), .in_data(in_data),
        .in_inv(in_inv), .abort(abort), .out_valid(ov[3]), .out_ready(out_ready),
        .out_data(od[3]), .busy(bz[3])
    );

    // Reference S-box from GF(2^8) inversion plus the affine map.
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, x);
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one block for one edge, then scramble the inputs to prove they were latched.
    task automatic issue(input logic [127:0] data, input logic inv);
        in_valid = 1'b1;
        in_data  = data;
        in_inv   = inv;
        tick();
        in_valid = 1'b0;
        in_data  = ~data;
        in_inv   = ~inv;
    endtask

    task automatic collect(input int budget);
        for (int d = 0; d < NDUT; d++) begin
            lat[d] = 0;
            res[d] = '0;
        end
        for (int c = 1; c <= budget; c++) begin
            tick();
            for (int d = 0; d < NDUT; d++) begin
                if (ov[d] && lat[d] == 0) begin
                    lat[d] = c;
                    res[d] = od[d];
                end
            end
        end
    endtask

    task automatic test_reset();
        #2;
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (ir[d] !== 1'b1 || ov[d] !== 1'b0 || bz[d] !== 1'b0 || od[d] !== 128'h0) begin
                errors++;
                $display("FAIL reset_state lanes=%0d got ir=%b ov=%b busy=%b data=%h want 1 0 0 0",
                         LANES_OF[d], ir[d], ov[d], bz[d], od[d]);
            end
        end
        #5 rst = 1'b0;
        tick();
    endtask

    task automatic test_forward();
        issue(FWD_IN, 1'b0);
        collect(20);
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (lat[d] !== 16 / LANES_OF[d]) begin
                errors++;
                $display("FAIL fwd_latency lanes=%0d got %0d want %0d", LANES_OF[d], lat[d], 16 / LANES_OF[d]);
            end
            checks++;
            if (res[d] !== FWD_OUT) begin
                errors++;
                $display("FAIL fwd_data lanes=%0d got %h want %h", LANES_OF[d], res[d], FWD_OUT);
            end
        end
    endtask

    task automatic test_inverse();
        issue(FWD_OUT, 1'b1);
        collect(20);
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (lat[d] !== 16 / LANES_OF[d]) begin
                errors++;
                $display("FAIL inv_latency lanes=%0d got %0d want %0d", LANES_OF[d], lat[d], 16 / LANES_OF[d]);
            end
            checks++;
            if (res[d] !== FWD_IN) begin
                errors++;
                $display("FAIL inv_data lanes=%0d got %h want %h", LANES_OF[d], res[d], FWD_IN);
            end
        end
    endtask

    task automatic test_spot();
        logic [127:0] want_f, want_i;
        want_f = 128'h6363_6363_6363_6363_6363_6363_6363_16ed;
        want_i = 128'h5252_5252_5252_5252_5252_5252_5252_5300;
        issue(128'h0000_0000_0000_0000_0000_0000_0000_ff53, 1'b0);
        collect(20);
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (res[d] !== want_f) begin
                errors++;
                $display("FAIL spot_fwd lanes=%0d got %h want %h", LANES_OF[d], res[d], want_f);
            end
        end
        issue(128'h0000_0000_0000_0000_0000_0000_0000_ed63, 1'b1);
        collect(20);
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (res[d] !== want_i) begin
                errors++;
                $display("FAIL spot_inv lanes=%0d got %h want %h", LANES_OF[d], res[d], want_i);
            end
        end
    endtask

    task automatic test_all_bytes();
        logic [127:0] data, want;
        for (int blk = 0; blk < 16; blk++) begin
            for (int k = 0; k < 16; k++) begin
                data[8*k +: 8] = 8'(blk * 16 + k);
                want[8*k +: 8] = sbox_ref(8'(blk * 16 + k));
            end
            issue(data, 1'b0);
            collect(20);
            for (int d = 0; d < NDUT; d++) begin
                checks++;
                if (res[d] !== want) begin
                    errors++;
                    $display("FAIL sweep_fwd blk=%0d lanes=%0d got %h want %h", blk, LANES_OF[d], res[d], want);
                end
            end
            issue(want, 1'b1);
            collect(20);
            for (int d = 0; d < NDUT; d++) begin
                checks++;
                if (res[d] !== data) begin
                    errors++;
                    $display("FAIL sweep_roundtrip blk=%0d lanes=%0d got %h want %h", blk, LANES_OF[d], res[d], data);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 128'h0;
        in_inv    = 1'b0;
        tick();
        in_data = FWD_IN;
        repeat (16) tick();
        for (int c = 0; c < 10; c++) begin
            for (int d = 0; d < NDUT; d++) begin
                checks++;
                if (ov[d] !== 1'b1 || od[d] !== ALL63 || ir[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL hold cyc=%0d lanes=%0d got ov=%b ir=%b data=%h want 1 0 %h",
                             c, LANES_OF[d], ov[d], ir[d], od[d], ALL63);
                end
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (ir[d] !== 1'b1 || ov[d] !== 1'b0) begin
                errors++;
                $display("FAIL release lanes=%0d got ir=%b ov=%b want 1 0", LANES_OF[d], ir[d], ov[d]);
            end
        end
        tick();
        in_valid = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (ir[d] !== 1'b0 || bz[d] !== 1'b1) begin
                errors++;
                $display("FAIL second_accept lanes=%0d got ir=%b busy=%b want 0 1", LANES_OF[d], ir[d], bz[d]);
            end
        end
        collect(20);
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (res[d] !== FWD_OUT || lat[d] !== 16 / LANES_OF[d]) begin
                errors++;
                $display("FAIL second_block lanes=%0d got %h lat=%0d want %h lat=%0d",
                         LANES_OF[d], res[d], lat[d], FWD_OUT, 16 / LANES_OF[d]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int first [NDUT];
        int second [NDUT];
        for (int d = 0; d < NDUT; d++) begin
            first[d]  = -1;
            second[d] = -1;
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = FWD_IN;
        in_inv    = 1'b0;
        for (int e = 0; e < 45; e++) begin
            for (int d = 0; d < NDUT; d++) begin
                if (ir[d]) begin
                    if (first[d] < 0) first[d] = e;
                    else if (second[d] < 0) second[d] = e;
                end
            end
            tick();
        end
        in_valid = 1'b0;
        repeat (25) tick();
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (first[d] !== 0 || second[d] - first[d] !== 16 / LANES_OF[d] + 2) begin
                errors++;
                $display("FAIL issue_interval lanes=%0d got first=%0d gap=%0d want 0 %0d",
                         LANES_OF[d], first[d], second[d] - first[d], 16 / LANES_OF[d] + 2);
            end
        end
    endtask

    task automatic test_abort();
        logic seen [NDUT];
        issue(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 1'b0);
        tick();
        for (int d = 0; d < NDUT; d++) seen[d] = (d < 3) ? ov[d] : 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (ir[d] !== 1'b1 || bz[d] !== 1'b0 || ov[d] !== 1'b0) begin
                errors++;
                $display("FAIL abort_idle lanes=%0d got ir=%b busy=%b ov=%b want 1 0 0",
                         LANES_OF[d], ir[d], bz[d], ov[d]);
            end
        end
        for (int c = 0; c < 20; c++) begin
            tick();
            for (int d = 0; d < 3; d++) if (ov[d]) seen[d] = 1'b1;
        end
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (seen[d] !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_output lanes=%0d got ov_seen=%b want 0", LANES_OF[d], seen[d]);
            end
        end
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = FWD_IN;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (ir[d] !== 1'b1 || bz[d] !== 1'b0) begin
                errors++;
                $display("FAIL abort_beats_valid lanes=%0d got ir=%b busy=%b want 1 0", LANES_OF[d], ir[d], bz[d]);
            end
        end
        issue(128'h0, 1'b0);
        collect(20);
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (res[d] !== ALL63 || lat[d] !== 16 / LANES_OF[d]) begin
                errors++;
                $display("FAIL after_abort lanes=%0d got %h lat=%0d want %h lat=%0d",
                         LANES_OF[d], res[d], lat[d], ALL63, 16 / LANES_OF[d]);
            end
        end
    endtask

    task automatic test_reset_mid();
        issue(FWD_IN, 1'b0);
        tick();
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (ir[d] !== 1'b1 || ov[d] !== 1'b0 || bz[d] !== 1'b0 || od[d] !== 128'h0) begin
                errors++;
                $display("FAIL async_reset lanes=%0d got ir=%b ov=%b busy=%b data=%h want 1 0 0 0",
                         LANES_OF[d], ir[d], ov[d], bz[d], od[d]);
            end
        end
        #10 rst = 1'b0;
        tick();
        issue(FWD_OUT, 1'b1);
        collect(20);
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (res[d] !== FWD_IN || lat[d] !== 16 / LANES_OF[d]) begin
                errors++;
                $display("FAIL after_reset lanes=%0d got %h lat=%0d want %h lat=%0d",
                         LANES_OF[d], res[d], lat[d], FWD_IN, 16 / LANES_OF[d]);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_inv    = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_forward();
        test_inverse();
        test_spot();
        test_all_bytes();
        test_backpressure();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
